inst_fetcher: RTL
=================

Name: inst_fetcher

Overview:
- Instruction fetch stage between the core's instruction memory bus and the decode stage.
- Issues sequential, word-aligned fetch requests from a PC register.
- Collects in-order responses into a small instruction buffer and hands {pc, inst} to decode with a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing the buffer and discarding stale in-flight responses.

Parameters:
- XLEN, 32, address/PC width.
- ILEN, 32, instruction width; equals the bus rdata width.
- BUF_DEPTH, 2, instruction buffer entries; must be >= 1.
- INIT_PC, 0, PC loaded at reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- membus_valid  out  1  fetch request valid
- membus_ready  in  1  memory accepts the request this cycle
- membus_addr  out  XLEN  byte address of the request
- membus_wen  out  1  constant 0 (fetch is read-only)
- membus_wdata  out  ILEN  constant 0
- membus_rvalid  in  1  response valid; exactly one per accepted request, in order, at least 1 cycle after acceptance
- membus_rdata  in  ILEN  response data
- redirect_valid  in  1  redirect fetch to redirect_pc
- redirect_pc  in  XLEN  new PC; bits [1:0] forced to 0 internally
- out_valid  out  1  buffer head holds an instruction
- out_ready  in  1  decode consumes the head
- out_pc  out  XLEN  PC of the head instruction
- out_inst  out  ILEN  head instruction

Behaviour:
- Reset (async, rst=1): pc=INIT_PC, state=IDLE, discard=0, buffer empty, membus_valid=0, out_valid=0, out_pc=0, out_inst=0.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: exactly one request accepted, response pending.
- Issue rule:
  - membus_valid=1 iff state==IDLE && count<BUF_DEPTH && !redirect_valid.
  - membus_valid depends only on registered state and redirect_valid; it never depends on membus_ready.
  - membus_addr=pc while valid.
  - On valid&&ready: pc<=pc+4 (wraps modulo 2^XLEN), state<=WAIT.
  - Holding: once membus_valid is asserted, addr stays stable until ready.
- Response, WAIT && membus_rvalid:
  - If discard==0, push {addr_of_request, rdata} into the buffer; the request address is held in a register.
  - If discard==1, drop the response and clear discard.
  - state<=IDLE.
  - Throughput is at most one instruction per 2 cycles with a 1-cycle-latency memory.
- Buffer is FIFO, count 0..BUF_DEPTH:
  - out_valid = count!=0; out_pc/out_inst = head.
  - Pop on out_valid&&out_ready.
  - Push and pop in the same cycle keeps count unchanged.
  - Overflow cannot occur: a request is issued only when count<BUF_DEPTH, and a pop can only increase room.
- Redirect (redirect_valid=1 in a cycle):
  - Buffer flushed (count<=0); any same-cycle pop is ignored.
  - pc<=redirect_pc & ~3.
  - No new request is issued that cycle.
  - If state==WAIT and no rvalid this cycle: discard<=1.
  - If state==WAIT and rvalid this cycle: the response is dropped, discard stays 0, state<=IDLE.
  - If state==IDLE: no effect on FSM.
  - Redirect has priority over push and pop. Back-to-back redirects: last one wins.
- Reset mid-operation: all state is cleared immediately. Memory is reset on the same rst, so no stale response is expected.
- Output stability: out_pc/out_inst are held while out_valid && !out_ready, unless a redirect occurs.

Decomposition:
- Shared package core_eei: XLEN, ILEN, INIT_PC, and typedefs Addr (logic [XLEN-1:0]) and Inst (logic [ILEN-1:0]).
- Sub-module fifo: generic FIFO parameterised by WIDTH and DEPTH, with push/pop/flush, count, and head outputs. It holds the {pc, inst} entries.
- inst_fetcher contains the FSM, PC, discard logic, and credit check.

Test Plan:
- Reset, then membus_ready=1 and 1-cycle memory (rdata=addr^0xFFFF_FFFF), out_ready=1 -> out_pc sequence 0x0, 0x4, 0x8, ... with out_inst=~pc; membus_wen always 0.
- out_ready=0 with BUF_DEPTH=2 -> exactly 2 requests (0x0, 0x4), then membus_valid stays 0. Raising out_ready yields 0x0 then 0x4, then fetch resumes at 0x8.
- membus_ready held 0 for 5 cycles with the request at 0x4 -> membus_valid=1 and addr=0x4 stable throughout; pc increments only on the accepting cycle.
- Redirect to 0x103 while in WAIT, response arrives 1 cycle later -> that response is dropped, the buffer is empty, and the next request addr is 0x100; out_pc=0x100.
- Redirect in the same cycle as rvalid, with 1 entry buffered -> response not pushed, buffer flushed, out_valid=0 the next cycle, next request at the redirect PC.
- Assert rst mid-WAIT with 2 entries buffered -> out_valid=0 and membus_valid=0 immediately; after release, first request at INIT_PC.

Source files
------------

// File: rtl/core_eei.sv
// Shared execution-environment constants and types for the core front end.
// Provides widths, reset PC, Addr/Inst typedefs and the fetch FSM encoding.
package core_eei;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] INIT_PC = '0;

  typedef logic [XLEN-1:0] Addr;
  typedef logic [ILEN-1:0] Inst;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_WAIT
  } fetch_state_e;

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with flush, occupancy count and a head output.
// Ports: push/wdata in, pop in, flush in, count/head out (head is 0 when empty).
module fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d        = nxt(wr_q);
      end
      if (pop) begin
        rd_d = nxt(rd_q);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign head  = (cnt_q != '0) ? mem_q[rd_q] : '0;

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: issues sequential word fetches, buffers in-order responses
// and hands {pc, inst} to decode. Ports: membus_* request/response side,
// redirect_valid/redirect_pc from execute, out_* valid/ready to decode.
module inst_fetcher
  import core_eei::*;
#(
  parameter int              XLEN      = core_eei::XLEN,
  parameter int              ILEN      = core_eei::ILEN,
  parameter int              BUF_DEPTH = 2,
  parameter logic [XLEN-1:0] INIT_PC   = core_eei::INIT_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            membus_valid,
  input  logic            membus_ready,
  output logic [XLEN-1:0] membus_addr,
  output logic            membus_wen,
  output logic [ILEN-1:0] membus_wdata,
  input  logic            membus_rvalid,
  input  logic [ILEN-1:0] membus_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int EW = XLEN + ILEN;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            discard_q, discard_d;

  logic [CW-1:0]   count;
  logic [EW-1:0]   head;
  logic            push;
  logic            pop;
  logic            accept;

  // Request gating uses only registered state plus redirect, never ready.
  assign membus_valid = !rst
                     && (state_q == FETCH_IDLE)
                     && (count < FULL)
                     && !redirect_valid;
  assign membus_addr  = pc_q;
  assign membus_wen   = 1'b0;
  assign membus_wdata = '0;
  assign accept       = membus_valid && membus_ready;

  assign out_valid = (count != '0);
  assign out_pc    = head[EW-1 -: XLEN];
  assign out_inst  = head[ILEN-1:0];
  assign pop       = out_valid && out_ready && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    push       = 1'b0;
    unique case (state_q)
      FETCH_IDLE: begin
        if (accept) begin
          req_addr_d = pc_q;
          pc_d       = pc_q + XLEN'(4);
          state_d    = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (membus_rvalid) begin
          // A response landing with a redirect, or after one, is stale.
          push      = !discard_q && !redirect_valid;
          discard_d = 1'b0;
          state_d   = FETCH_IDLE;
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
    if (redirect_valid) begin
      pc_d = redirect_pc & ~XLEN'(3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= INIT_PC;
      req_addr_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
    end
  end

  fifo #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({req_addr_q, membus_rdata}),
    .pop   (pop),
    .flush (redirect_valid),
    .count (count),
    .head  (head)
  );

endmodule
